// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions.
//   - uart_state_e     : receiver FSM states
//   - UART_DATA_W      : payload width of one frame
//   - symbol_edge_time : clock cycles per symbol (truncated)
//   - sample_time      : cycle offset of the mid-symbol sample
// The transmitter must call the same functions so that both sides
// derive identical bit timing from the same CLOCK_FREQ/BAUD_RATE.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int sample_time(input int clock_freq, input int baud_rate);
        return symbol_edge_time(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   clk  : destination clock
//   rst  : synchronous active-high reset, loads RESET_VAL into both flops
//   i_d  : asynchronous input
//   o_q  : synchronized output (two cycles of latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with a ready/valid byte output.
//   clk            : core clock
//   rst            : synchronous active-high reset
//   serial_in      : asynchronous serial line, idle high
//   data_out       : received byte, meaningful while data_out_valid
//   data_out_valid : byte available
//   data_out_ready : consumer accepts the byte
//   framing_error  : one-cycle pulse, stop bit sampled low
//   overrun        : one-cycle pulse, byte finished while output full (dropped)
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 10_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   serial_in,
    output logic [UART_DATA_W-1:0] data_out,
    output logic                   data_out_valid,
    input  logic                   data_out_ready,
    output logic                   framing_error,
    output logic                   overrun
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TIME      = sample_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
    localparam int BIT_W            = $clog2(UART_DATA_W);

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(UART_DATA_W - 1);

    // Fewer than 4 cycles per symbol leaves no room for a mid-symbol sample.
    generate
        if (SYMBOL_EDGE_TIME < 4) begin : g_bad_baud
            $error("uart_receiver: CLOCK_FREQ/BAUD_RATE must be >= 4");
        end
    endgenerate

    logic w_rx;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .i_d (serial_in),
        .o_q (w_rx)
    );

    uart_state_e            r_state, w_state;
    logic [CNT_W-1:0]       r_clk_cnt, w_clk_cnt;
    logic [BIT_W-1:0]       r_bit_cnt, w_bit_cnt;
    logic [UART_DATA_W-1:0] r_shift, w_shift;
    logic [UART_DATA_W-1:0] r_data, w_data;
    logic                   r_valid, w_valid;
    logic                   r_ferr, w_ferr;
    logic                   r_ovr, w_ovr;
    logic                   w_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_clk_cnt <= w_clk_cnt;
            r_bit_cnt <= w_bit_cnt;
            r_shift   <= w_shift;
            r_data    <= w_data;
            r_valid   <= w_valid;
            r_ferr    <= w_ferr;
            r_ovr     <= w_ovr;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_clk_cnt = r_clk_cnt + 1'b1;
        w_bit_cnt = r_bit_cnt;
        w_shift   = r_shift;
        w_load    = 1'b0;
        w_ferr    = 1'b0;
        w_ovr     = 1'b0;

        case (r_state)
            IDLE: begin
                w_clk_cnt = '0;
                if (!w_rx) begin
                    w_state = START;
                end
            end

            // Re-check the start bit half a symbol in; a high line here was a glitch.
            START: begin
                if (r_clk_cnt == SAMPLE_CNT) begin
                    w_clk_cnt = '0;
                    if (!w_rx) begin
                        w_state   = DATA;
                        w_bit_cnt = '0;
                    end else begin
                        w_state = IDLE;
                    end
                end
            end

            // LSB arrives first, so shifting in at the MSB leaves bit 0 at [0].
            DATA: begin
                if (r_clk_cnt == LAST_CNT) begin
                    w_clk_cnt = '0;
                    w_shift   = {w_rx, r_shift[UART_DATA_W-1:1]};
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state = STOP;
                    end else begin
                        w_bit_cnt = r_bit_cnt + 1'b1;
                    end
                end
            end

            // A byte being accepted this cycle frees the slot, so it is not an overrun.
            STOP: begin
                if (r_clk_cnt == LAST_CNT) begin
                    w_clk_cnt = '0;
                    if (w_rx) begin
                        w_state = IDLE;
                        if (!r_valid || data_out_ready) begin
                            w_load = 1'b1;
                        end else begin
                            w_ovr = 1'b1;
                        end
                    end else begin
                        w_ferr  = 1'b1;
                        w_state = BREAK;
                    end
                end
            end

            // Held-low line: wait for it to return high before looking for a start.
            BREAK: begin
                w_clk_cnt = '0;
                if (w_rx) begin
                    w_state = IDLE;
                end
            end

            default: begin
                w_clk_cnt = '0;
                w_state   = IDLE;
            end
        endcase
    end

    // A fresh byte overrides a same-cycle handshake and keeps valid high.
    always_comb begin
        w_data  = r_data;
        w_valid = r_valid;
        if (w_load) begin
            w_data  = r_shift;
            w_valid = 1'b1;
        end else if (r_valid && data_out_ready) begin
            w_valid = 1'b0;
        end
    end

    assign data_out       = r_data;
    assign data_out_valid = r_valid;
    assign framing_error  = r_ferr;
    assign overrun        = r_ovr;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: self-checking bench for uart_receiver at 5 cycles/bit.
module tb_uart_receiver;

    localparam int BIT_CYC = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;

    // Everything the consumer side observes, recorded by a passive monitor.
    int         cyc = 0;
    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;

    uart_receiver #(
        .CLOCK_FREQ(50_000_000),
        .BAUD_RATE (10_000_000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .framing_error  (framing_error),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (data_out_valid && data_out_ready) begin
                rx_q.push_back(data_out);
                rx_t.push_back(cyc);
            end
            if (framing_error) ferr_cnt <= ferr_cnt + 1;
            if (overrun)       ovr_cnt  <= ovr_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 8N1 frame from the wire's point of view: start, 8 data LSB first, stop.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        serial_in = 1'b0;
        tick(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            tick(BIT_CYC);
        end
        serial_in = stop_bit;
        tick(BIT_CYC);
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        serial_in      = 1'b1;
        data_out_ready = 1'b1;
        tick(3);
        @(negedge clk);
        n_cmp += 4;
        if (data_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", data_out_valid); end
        if (data_out !== 8'h00)      begin n_bad++; $display("FAIL reset_data got %h want 00", data_out); end
        if (framing_error !== 1'b0)  begin n_bad++; $display("FAIL reset_ferr got %b want 0", framing_error); end
        if (overrun !== 1'b0)        begin n_bad++; $display("FAIL reset_ovr got %b want 0", overrun); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(5);
    endtask

    task automatic test_single();
        int base = rx_q.size();
        int f0 = ferr_cnt;
        int o0 = ovr_cnt;
        int t0 = cyc;
        send_frame(8'h61, 1'b1);
        tick(5);
        n_cmp++;
        if (rx_q.size() - base !== 1) begin
            n_bad++; $display("FAIL single_count got %0d want 1", rx_q.size() - base);
        end else begin
            n_cmp += 2;
            if (rx_q[base] !== 8'h61) begin n_bad++; $display("FAIL single_data got %h want 61", rx_q[base]); end
            if (rx_t[base] - t0 !== 50) begin n_bad++; $display("FAIL single_latency got %0d want 50", rx_t[base] - t0); end
        end
        n_cmp += 2;
        if (ferr_cnt - f0 !== 0) begin n_bad++; $display("FAIL single_ferr got %0d want 0", ferr_cnt - f0); end
        if (ovr_cnt - o0 !== 0)  begin n_bad++; $display("FAIL single_ovr got %0d want 0", ovr_cnt - o0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        int base = rx_q.size();
        int f0 = ferr_cnt;
        int o0 = ovr_cnt;
        exp_b[0] = 8'h73; exp_b[1] = 8'h77; exp_b[2] = 8'h20;
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
        tick(5);
        n_cmp++;
        if (rx_q.size() - base !== 3) begin
            n_bad++; $display("FAIL b2b_count got %0d want 3", rx_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (rx_q[base+i] !== exp_b[i]) begin
                    n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", i, rx_q[base+i], exp_b[i]);
                end
            end
        end
        n_cmp++;
        if ((ferr_cnt - f0) + (ovr_cnt - o0) !== 0) begin
            n_bad++; $display("FAIL b2b_errors got %0d want 0", (ferr_cnt - f0) + (ovr_cnt - o0));
        end
    endtask

    task automatic test_overrun();
        int base = rx_q.size();
        int f0 = ferr_cnt;
        int o0 = ovr_cnt;
        data_out_ready = 1'b0;
        send_frame(8'hca, 1'b1);
        send_frame(8'hfe, 1'b1);
        tick(5);
        @(negedge clk);
        n_cmp += 4;
        if (data_out !== 8'hca)      begin n_bad++; $display("FAIL ovr_data got %h want ca", data_out); end
        if (data_out_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid got %b want 1", data_out_valid); end
        if (ovr_cnt - o0 !== 1)      begin n_bad++; $display("FAIL ovr_pulses got %0d want 1", ovr_cnt - o0); end
        if (ferr_cnt - f0 !== 0)     begin n_bad++; $display("FAIL ovr_ferr got %0d want 0", ferr_cnt - f0); end
        @(posedge clk);
        #1;
        data_out_ready = 1'b1;
        tick(1);
        data_out_ready = 1'b0;
        @(negedge clk);
        n_cmp += 2;
        if (data_out_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_drain_valid got %b want 0", data_out_valid); end
        if (rx_q.size() - base !== 1 || rx_q[rx_q.size()-1] !== 8'hca) begin
            n_bad++; $display("FAIL ovr_accepted got %0d bytes last %h want 1 byte ca", rx_q.size() - base, rx_q[rx_q.size()-1]);
        end
        @(posedge clk);
        #1;
        data_out_ready = 1'b1;
        tick(2);
    endtask

    task automatic test_framing();
        int base = rx_q.size();
        int f0 = ferr_cnt;
        int o0 = ovr_cnt;
        send_frame(8'h55, 1'b0);
        tick(30);
        serial_in = 1'b1;
        tick(10);
        n_cmp += 3;
        if (ferr_cnt - f0 !== 1)       begin n_bad++; $display("FAIL ferr_pulses got %0d want 1", ferr_cnt - f0); end
        if (rx_q.size() - base !== 0)  begin n_bad++; $display("FAIL ferr_bytes got %0d want 0", rx_q.size() - base); end
        if (ovr_cnt - o0 !== 0)        begin n_bad++; $display("FAIL ferr_ovr got %0d want 0", ovr_cnt - o0); end
        send_frame(8'h0d, 1'b1);
        tick(5);
        n_cmp++;
        if (rx_q.size() - base !== 1 || rx_q[rx_q.size()-1] !== 8'h0d) begin
            n_bad++; $display("FAIL ferr_recover got %0d bytes last %h want 1 byte 0d", rx_q.size() - base, rx_q[rx_q.size()-1]);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] b = 8'($urandom);
        int base = rx_q.size();
        int f0 = ferr_cnt;
        int o0 = ovr_cnt;
        serial_in = 1'b0;
        tick(1);
        serial_in = 1'b1;
        tick(10);
        n_cmp += 2;
        if (rx_q.size() - base !== 0) begin n_bad++; $display("FAIL glitch_bytes got %0d want 0", rx_q.size() - base); end
        if ((ferr_cnt - f0) + (ovr_cnt - o0) !== 0) begin
            n_bad++; $display("FAIL glitch_errors got %0d want 0", (ferr_cnt - f0) + (ovr_cnt - o0));
        end
        // A glitch one cycle after the first, followed 5 cycles later by a real frame.
        serial_in = 1'b0;
        tick(1);
        serial_in = 1'b1;
        tick(5);
        send_frame(b, 1'b1);
        tick(5);
        n_cmp++;
        if (rx_q.size() - base !== 1 || rx_q[rx_q.size()-1] !== b) begin
            n_bad++; $display("FAIL glitch_recover got %0d bytes last %h want 1 byte %h", rx_q.size() - base, rx_q[rx_q.size()-1], b);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int base = rx_q.size();
        int f0 = ferr_cnt;
        int o0 = ovr_cnt;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            tick($urandom_range(0, 6));
        end
        tick(5);
        n_cmp++;
        if (rx_q.size() - base !== exp_q.size()) begin
            n_bad++; $display("FAIL rand_count got %0d want %0d", rx_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (rx_q[base+i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL rand_data[%0d] got %h want %h", i, rx_q[base+i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if ((ferr_cnt - f0) + (ovr_cnt - o0) !== 0) begin
            n_bad++; $display("FAIL rand_errors got %0d want 0", (ferr_cnt - f0) + (ovr_cnt - o0));
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b = 8'h3e;
        int base;
        int f0 = ferr_cnt;
        int o0 = ovr_cnt;
        serial_in = 1'b0;
        tick(BIT_CYC);
        for (int i = 0; i < 4; i++) begin
            serial_in = b[i];
            tick(BIT_CYC);
        end
        serial_in = b[4];
        tick(2);
        rst = 1'b1;
        tick(2);
        @(negedge clk);
        n_cmp += 4;
        if (data_out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", data_out_valid); end
        if (data_out !== 8'h00)      begin n_bad++; $display("FAIL rstmid_data got %h want 00", data_out); end
        if (framing_error !== 1'b0)  begin n_bad++; $display("FAIL rstmid_ferr got %b want 0", framing_error); end
        if (overrun !== 1'b0)        begin n_bad++; $display("FAIL rstmid_ovr got %b want 0", overrun); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        serial_in = 1'b1;
        tick(10);
        base = rx_q.size();
        send_frame(8'h31, 1'b1);
        tick(5);
        n_cmp += 2;
        if (rx_q.size() - base !== 1 || rx_q[rx_q.size()-1] !== 8'h31) begin
            n_bad++; $display("FAIL rstmid_recover got %0d bytes last %h want 1 byte 31", rx_q.size() - base, rx_q[rx_q.size()-1]);
        end
        if ((ferr_cnt - f0) + (ovr_cnt - o0) !== 0) begin
            n_bad++; $display("FAIL rstmid_errors got %0d want 0", (ferr_cnt - f0) + (ovr_cnt - o0));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_framing();
        test_glitch();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
